// File: rtl/wrapper_pkg.sv
// Shared definitions for the wrapper's result path: transmitter state
// encoding and the serial idle level.
package wrapper_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;

  localparam logic TXD_IDLE = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data. Flags are
// decoded from the registered count, so a same-cycle pop never frees room for a push.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/result_tx_buffer.sv
// Result stream sink: buffers controller result words and serialises each
// one as an 8N1 frame on txd, chaining frames with no idle gap.
module result_tx_buffer
  import wrapper_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              txd
);
  localparam int AW   = $clog2(DEPTH);
  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(DATA_W + 1);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [BITW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty, pop;
  logic [AW:0]       fifo_count;
  logic              baud_last;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_req),
    .din   (wr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign full      = fifo_full;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign ovf       = ovf_q;

  // A write while full is lost; losing a word must never be masked by a clear.
  assign ovf_d = (wr_req & fifo_full) | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = START;
          shift_d = fifo_dout;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BITW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more words are queued.
          if (!fifo_empty) begin
            state_d = START;
            shift_d = fifo_dout;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    txd = TXD_IDLE;
    case (state_q)
      IDLE:    pop = !fifo_empty;
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
      STOP:    pop = baud_last && !fifo_empty;
      default: txd = TXD_IDLE;
    endcase
  end
endmodule

// File: tb/tb_result_tx_buffer.sv
// Bench for result_tx_buffer: a frame-level reference model predicts every
// output each cycle, and a line decoder checks received words and frame spacing.
module tb_result_tx_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 16;
  localparam int FRAME = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, busy, ovf, txd;

  always #5 clk = ~clk;

  result_tx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .full    (full),
    .busy    (busy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .txd     (txd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of waiting words, cycles left in current frame.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_tx[$];
  int            rem;
  logic [DW-1:0] cur;
  logic          movf;

  // Line decoder state.
  logic          rx_act;
  int            rx_cnt;
  logic [DW-1:0] rx_b;
  int            rx_n;
  int            rx_start[$];
  int            ncyc;

  logic s_txd, s_busy, s_full, s_ovf;

  function automatic logic m_txd();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME - rem) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == DW + 1) return 1'b1;
    return cur[idx-1];
  endfunction

  task automatic m_reset();
    mq.delete();
    exp_tx.delete();
    rem  = 0;
    cur  = '0;
    movf = 1'b0;
  endtask

  task automatic m_step(input logic w, input logic [DW-1:0] d, input logic c);
    bit            full0, dopop;
    logic [DW-1:0] hd;
    full0 = (mq.size() == DEPTH);
    dopop = (rem <= 1) && (mq.size() > 0);
    hd    = dopop ? mq[0] : '0;
    movf  = (w && full0) || (movf && !c);
    if (w && !full0) mq.push_back(d);
    if (dopop) begin
      void'(mq.pop_front());
      cur = hd;
      rem = FRAME;
      exp_tx.push_back(hd);
    end else if (rem > 0) begin
      rem--;
    end
  endtask

  task automatic rx_step();
    int k;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (txd == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        rx_start.push_back(ncyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > CPB && (rx_cnt % CPB) == CPB / 2) begin
        k = rx_cnt / CPB - 1;
        if (k < DW) begin
          rx_b[k] = txd;
        end else begin
          chk("rx_stop", txd, 1);
          chk("rx_pending", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) chk("rx_data", rx_b, exp_tx.pop_front());
          rx_n++;
          rx_act = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic c);
    @(negedge clk);
    s_txd  = txd;
    s_busy = busy;
    s_full = full;
    s_ovf  = ovf;
    chk("txd", txd, m_txd());
    chk("busy", busy, (rem > 0) || (mq.size() > 0));
    chk("full", full, mq.size() == DEPTH);
    chk("ovf", ovf, movf);
    rx_step();
    wr_req  = w;
    wr_data = d;
    ovf_clr = c;
    if (rst) m_reset();
    else     m_step(w, d, c);
    ncyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] a5;
    int            n0, found;

    m_reset();
    rx_act = 1'b0;
    rx_cnt = 0;
    rx_n   = 0;
    ncyc   = 0;
    rx_b   = '0;
    idle(3);
    chk("rst_txd", s_txd, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_full", s_full, 0);
    chk("rst_ovf", s_ovf, 0);
    rst = 1'b0;
    idle(4);

    // Single word, directed timing checks against cycle offsets.
    a5 = 8'hA5;
    cyc(1'b1, a5, 1'b0);
    for (int k = 1; k <= 170; k++) begin
      cyc(1'b0, '0, 1'b0);
      if (k == 1)   chk("a5_pre_start", s_txd, 1);
      if (k == 2)   chk("a5_start", s_txd, 0);
      for (int b = 0; b < DW; b++)
        if (k == 2 + CPB * (b + 1) + CPB / 2) chk("a5_bit", s_txd, a5[b]);
      if (k == 2 + CPB * 9 + CPB / 2) chk("a5_stop", s_txd, 1);
      if (k == 161) chk("a5_busy_hi", s_busy, 1);
      if (k == 162) chk("a5_busy_lo", s_busy, 0);
    end

    // Job burst: four contiguous frames.
    n0 = rx_start.size();
    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0);
    idle(4 * FRAME + 20);
    chk("burst_frames", rx_start.size() - n0, 4);
    for (int i = 1; i < 4; i++)
      if (rx_start.size() >= n0 + 4)
        chk("burst_gap", rx_start[n0+i] - rx_start[n0+i-1], FRAME);

    // Overflow: six back-to-back writes, sixth is dropped.
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(8'h11 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("ovf_set", s_ovf, 1);
    idle(100);
    chk("ovf_held", s_ovf, 1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("ovf_cleared", s_ovf, 0);
    idle(5 * FRAME + 20);

    // Full FIFO with a write on the last stop cycle.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h30 + i), 1'b0);
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (rem == 1 && mq.size() == DEPTH) found = 1;
      else cyc(1'b0, '0, 1'b0);
    end
    chk("fullpop_reached", found, 1);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("fullpop_ovf", s_ovf, 1);
    chk("fullpop_full", s_full, 0);
    cyc(1'b0, '0, 1'b1);
    idle(5 * FRAME + 20);

    // Reset during data bit 3 of 8'hFF.
    cyc(1'b1, 8'hFF, 1'b0);
    idle(70);
    @(posedge clk);
    #3 rst = 1'b1;
    m_reset();
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_busy", busy, 0);
    idle(3);
    rst = 1'b0;
    n0 = rx_n;
    idle(2 * FRAME);
    chk("midrst_no_frame", rx_n - n0, 0);

    // Pointer wrap: ten spaced words.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, DW'($urandom_range(255)), 1'b0);
      idle(FRAME + 5);
    end

    // Random traffic.
    for (int i = 0; i < 5000; i++)
      cyc($urandom_range(39) == 0, DW'($urandom_range(255)), $urandom_range(99) == 0);
    idle(6 * FRAME);
    chk("rx_drained", exp_tx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
